rvv_backend_retire_vrf_wr: RTL and testbench
============================================

Name: rvv_backend_retire_vrf_wr

Overview:
- Retire-to-VRF write stage: accepts up to NUM_RT_UOP retired uops per cycle and merges their destination writes into per-register, bit-granular write-enable and write-data vectors.
- Drives the VRF write port (vrf_wr_wenb_full / vrf_wr_data_full) through one pipeline register, honouring a VRF stall.
- Counts retired uops and completed instructions (last uop) for debug and performance reporting.

Parameters:
- VLEN, 128, vector register width in bits; must be a multiple of 8.
- NUM_RT_UOP, 4, number of retire lanes per cycle.
- NUM_VREG, 32, number of architectural vector registers.
- CNT_W, 32, width of the retire counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- rt_valid  in  NUM_RT_UOP  per-lane retire valid; lane 0 is oldest.
- rt_ready  out  NUM_RT_UOP  per-lane accept.
- rt_vd  in  NUM_RT_UOP x 5  destination register index.
- rt_vd_benb  in  NUM_RT_UOP x VLEN/8  byte enables.
- rt_vd_data  in  NUM_RT_UOP x VLEN  write data.
- rt_last_uop  in  NUM_RT_UOP  uop is the last of its instruction.
- vrf_stall  in  1  VRF cannot accept a write this cycle.
- vrf_wr_wenb_full  out  NUM_VREG x VLEN  bit write enables.
- vrf_wr_data_full  out  NUM_VREG x VLEN  write data.
- uop_retired_cnt  out  CNT_W  accepted uop count.
- insn_retired_cnt  out  CNT_W  accepted last-uop count.
- rt_order_err  out  1  sticky ordering error.

Behaviour:
- Reset: synchronous, active-low on rst_n, sampled at posedge clk. All outputs and registers clear to 0.
- Ready: rt_ready[i] = ~vrf_stall for all lanes (combinational). A lane is accepted when rt_valid[i] & rt_ready[i].
- Merge (combinational, on the accepted set):
  - Each byte enable expands to 8 bit enables.
  - For register r, wenb[r] is the OR of the expanded enables of every accepted lane with rt_vd == r.
  - Data per byte comes from the highest-index accepted lane writing that byte (youngest wins).
  - Bytes with no enable carry data 0.
- Pipeline register, latency exactly 1 cycle:
  - If ~vrf_stall: output registers load the merged result; with no lane valid they load 0.
  - If vrf_stall: outputs hold their previous values and no new lane is accepted.
- A write posted while stall rises is held until stall drops. The VRF consumes it on the first cycle with vrf_stall=0, and then the next merge loads.
- Counters:
  - uop_retired_cnt += popcount(accepted lanes).
  - insn_retired_cnt += popcount(accepted & rt_last_uop).
  - Both update one cycle after acceptance and wrap modulo 2^CNT_W.
- Boundary cases:
  - All lanes writing the same vd with full enables: the lane NUM_RT_UOP-1 data wins.
  - A register index >= NUM_VREG is ignored.
  - An all-zero benb still counts as a uop.
- Reset mid-stall discards the held write.

Optional Feature:
- RVV_RT_ORDER_CHK_EN defined:
  - rt_order_err sets when an accepted cycle has rt_valid non-contiguous from lane 0 (some lane i valid while a lane j<i is not).
  - It stays set until reset.
  - Simulation also reports $error.
- Undefined: rt_order_err is tied 0 and no check logic is built.

Decomposition:
- rvv_backend_pkg holds:
  - typedef rt_wr_uop_t {vd, benb, data, last};
  - the constant VLENB = VLEN/8;
  - the localparam for the register-index width.
- Sub-module rvv_rt_benb_expand: byte-to-bit enable expansion, instantiated once per lane.

Test Plan:
- Lane 0 only, vd=3, benb=16'hFFFF, data=A5..A5 -> next cycle wenb[3]=all 1s, data[3]=A5..A5, other regs 0; uop_cnt=1.
- Lanes 0 and 1 both vd=7 full enables, data 0x11.. and 0x22.. -> data[7]=0x22.., wenb[7] all 1s.
- Lane0 vd=2 benb=16'h00FF, lane1 vd=2 benb=16'hFF00 -> wenb[2] all 1s, low half lane0 data, high half lane1 data.
- vrf_stall=1 for 3 cycles after a write to vd=5 -> rt_ready=0, outputs hold vd=5 write for 3 cycles, counters frozen.
- Four lanes valid, lanes 1 and 3 with rt_last_uop=1 -> uop_cnt +4, insn_cnt +2; preload uop_cnt near 2^CNT_W-1 -> wrap to 2.
- With RVV_RT_ORDER_CHK_EN, rt_valid=4'b0101 -> rt_order_err=1 next cycle, held until rst_n=0 at posedge.

Source files
------------

// File: rtl/rvv_backend_pkg.sv
// Shared types and constants for the retire-to-VRF write stage.
// Provides the retire uop struct, byte-lane width and register-index width.
// Pure declarations: no latency, no backpressure.
package rvv_backend_pkg;

   localparam int VLEN       = 128;
   localparam int VLENB      = VLEN / 8;
   localparam int NUM_RT_UOP = 4;
   localparam int NUM_VREG   = 32;
   localparam int CNT_W      = 32;
   localparam int VD_W       = 5;

   // One retiring uop's destination write.
   typedef struct packed {
      logic [VD_W-1:0]  vd;
      logic [VLENB-1:0] benb;
      logic [VLEN-1:0]  data;
      logic             last;
   } rt_wr_uop_t;

endpackage

// File: rtl/rvv_backend_retire_vrf_wr_if.sv
// Retire bus: per-lane valid/ready plus the uop payload, lane 0 oldest.
// Ports: rt_valid, rt_ready, rt_uop (vd, benb, data, last per lane).
// Pure wiring: no latency; ready is driven by the consumer.
interface rvv_backend_retire_vrf_wr_if;
   import rvv_backend_pkg::*;

   logic [NUM_RT_UOP-1:0]             rt_valid;
   logic [NUM_RT_UOP-1:0]             rt_ready;
   rt_wr_uop_t [NUM_RT_UOP-1:0]       rt_uop;

   modport master (output rt_valid, output rt_uop, input rt_ready);
   modport slave  (input rt_valid, input rt_uop, output rt_ready);
endinterface

// File: rtl/rvv_rt_benb_expand.sv
// Expands a VLENB-bit byte enable into a VLEN-bit bit enable.
// Ports: benb in, bit_en out. Combinational, zero latency.
// No handshake, so no backpressure.
module rvv_rt_benb_expand
   import rvv_backend_pkg::*;
(
   input  logic [VLENB-1:0] benb,
   output logic [VLEN-1:0]  bit_en
);

   for (genvar b = 0; b < VLENB; b++) begin : g_byte
      assign bit_en[8*b +: 8] = {8{benb[b]}};
   end

endmodule

// File: rtl/rvv_backend_retire_vrf_wr.sv
// Retire-to-VRF write: merges up to NUM_RT_UOP retired uops per cycle into
// per-register bit-enable/data vectors, registered once toward the VRF.
// Ports: clk, rst_n (sync, active low), rt (retire bus slave), vrf_stall,
//   vrf_wr_wenb_full, vrf_wr_data_full, uop_retired_cnt, insn_retired_cnt,
//   rt_order_err.
// Latency 1 cycle; vrf_stall drops rt_ready on all lanes and holds outputs.
// Optional macro RVV_RT_ORDER_CHK_EN builds the sticky lane-ordering check.
module rvv_backend_retire_vrf_wr
   import rvv_backend_pkg::*;
#(
   parameter int CNT_W = rvv_backend_pkg::CNT_W
) (
   input  logic                             clk,
   input  logic                             rst_n,
   rvv_backend_retire_vrf_wr_if.slave       rt,
   input  logic                             vrf_stall,
   output logic [NUM_VREG-1:0][VLEN-1:0]    vrf_wr_wenb_full,
   output logic [NUM_VREG-1:0][VLEN-1:0]    vrf_wr_data_full,
   output logic [CNT_W-1:0]                 uop_retired_cnt,
   output logic [CNT_W-1:0]                 insn_retired_cnt,
   output logic                             rt_order_err
);

   logic [NUM_RT_UOP-1:0]            acc;
   logic [NUM_RT_UOP-1:0][VLEN-1:0]  lane_bit_en;
   logic [NUM_VREG-1:0][VLEN-1:0]    merge_wenb;
   logic [NUM_VREG-1:0][VLEN-1:0]    merge_data;
   logic [CNT_W-1:0]                 uop_inc;
   logic [CNT_W-1:0]                 insn_inc;

   assign rt.rt_ready = {NUM_RT_UOP{~vrf_stall}};
   assign acc         = rt.rt_valid & rt.rt_ready;

   for (genvar l = 0; l < NUM_RT_UOP; l++) begin : g_lane
      rvv_rt_benb_expand u_expand (
         .benb   (rt.rt_uop[l].benb),
         .bit_en (lane_bit_en[l])
      );
   end

   // Lanes are walked oldest to youngest so a younger lane overwrites the
   // bytes it enables. Indices with no matching register are dropped simply
   // because no r ever matches them.
   always_comb begin
      merge_wenb = '0;
      merge_data = '0;
      for (int r = 0; r < NUM_VREG; r++) begin
         for (int l = 0; l < NUM_RT_UOP; l++) begin
            if (acc[l] && (rt.rt_uop[l].vd == VD_W'(r))) begin
               merge_wenb[r] = merge_wenb[r] | lane_bit_en[l];
               merge_data[r] = (merge_data[r] & ~lane_bit_en[l])
                             | (rt.rt_uop[l].data & lane_bit_en[l]);
            end
         end
      end
   end

   always_comb begin
      uop_inc  = '0;
      insn_inc = '0;
      for (int l = 0; l < NUM_RT_UOP; l++) begin
         uop_inc  = uop_inc  + {{(CNT_W-1){1'b0}}, acc[l]};
         insn_inc = insn_inc + {{(CNT_W-1){1'b0}}, acc[l] & rt.rt_uop[l].last};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vrf_wr_wenb_full <= '0;
         vrf_wr_data_full <= '0;
         uop_retired_cnt  <= '0;
         insn_retired_cnt <= '0;
      end else if (!vrf_stall) begin
         vrf_wr_wenb_full <= merge_wenb;
         vrf_wr_data_full <= merge_data;
         uop_retired_cnt  <= uop_retired_cnt  + uop_inc;
         insn_retired_cnt <= insn_retired_cnt + insn_inc;
      end
   end

`ifdef RVV_RT_ORDER_CHK_EN
   // Contiguous-from-lane-0 means valid is of the form 0..01..1, which is
   // exactly when valid & (valid + 1) is zero.
   logic [NUM_RT_UOP-1:0] valid_inc;
   logic                  order_bad;

   assign valid_inc = rt.rt_valid + NUM_RT_UOP'(1);
   assign order_bad = !vrf_stall && ((rt.rt_valid & valid_inc) != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rt_order_err <= 1'b0;
      end else if (order_bad) begin
         rt_order_err <= 1'b1;
      end
      assert (!(rst_n && order_bad))
         else $error("retire lanes not contiguous from lane 0: %b", rt.rt_valid);
   end
`else
   assign rt_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvv_backend_retire_vrf_wr.sv
module tb_rvv_backend_retire_vrf_wr;
   import rvv_backend_pkg::*;

   localparam int CW = 4;

   logic                          clk;
   logic                          rst_n;
   logic                          vrf_stall;
   logic [NUM_VREG-1:0][VLEN-1:0] wenb;
   logic [NUM_VREG-1:0][VLEN-1:0] wdat;
   logic [CW-1:0]                 uop_cnt;
   logic [CW-1:0]                 insn_cnt;
   logic                          order_err;
   logic                          exp_err;

   int checks   = 0;
   int failures = 0;

   localparam logic [VLEN-1:0] ONES = {VLEN{1'b1}};

   rvv_backend_retire_vrf_wr_if rt_if ();

   rvv_backend_retire_vrf_wr #(.CNT_W(CW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rt               (rt_if.slave),
      .vrf_stall        (vrf_stall),
      .vrf_wr_wenb_full (wenb),
      .vrf_wr_data_full (wdat),
      .uop_retired_cnt  (uop_cnt),
      .insn_retired_cnt (insn_cnt),
      .rt_order_err     (order_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [VLEN-1:0] rep(input logic [7:0] b);
      return {VLENB{b}};
   endfunction

   task automatic set_lane(input int l, input logic [4:0] vd, input logic [VLENB-1:0] benb,
                           input logic [VLEN-1:0] data, input logic last);
      rt_if.rt_uop[l].vd   = vd;
      rt_if.rt_uop[l].benb = benb;
      rt_if.rt_uop[l].data = data;
      rt_if.rt_uop[l].last = last;
   endtask

   // Inputs change on the falling edge; outputs are checked on the next one.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
`ifdef RVV_RT_ORDER_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      rst_n           = 1'b0;
      vrf_stall       = 1'b0;
      rt_if.rt_valid  = '0;
      rt_if.rt_uop    = '0;
      @(negedge clk);
      cyc();
      chk("rst_wenb3", wenb[3], '0);
      chk("rst_data3", wdat[3], '0);
      chk("rst_uop", uop_cnt, 0);
      chk("rst_insn", insn_cnt, 0);
      chk("rst_err", order_err, 0);
      chk("ready_idle", rt_if.rt_ready, 4'hF);
      rst_n = 1'b1;
      cyc();

      // single lane full write
      set_lane(0, 5'd3, 16'hFFFF, rep(8'hA5), 1'b1);
      rt_if.rt_valid = 4'b0001;
      cyc();
      chk("one_wenb3", wenb[3], ONES);
      chk("one_data3", wdat[3], rep(8'hA5));
      chk("one_wenb0", wenb[0], '0);
      chk("one_data4", wdat[4], '0);
      chk("one_uop", uop_cnt, 1);
      chk("one_insn", insn_cnt, 1);

      // two lanes same register, younger wins
      set_lane(0, 5'd7, 16'hFFFF, rep(8'h11), 1'b0);
      set_lane(1, 5'd7, 16'hFFFF, rep(8'h22), 1'b0);
      rt_if.rt_valid = 4'b0011;
      cyc();
      chk("same_data7", wdat[7], rep(8'h22));
      chk("same_wenb7", wenb[7], ONES);
      chk("same_wenb3_clr", wenb[3], '0);
      chk("same_uop", uop_cnt, 3);

      // split halves of one register
      set_lane(0, 5'd2, 16'h00FF, rep(8'h11), 1'b0);
      set_lane(1, 5'd2, 16'hFF00, rep(8'h22), 1'b0);
      cyc();
      chk("split_wenb2", wenb[2], ONES);
      chk("split_data2", wdat[2], {{(VLEN/2){1'b0}} | rep(8'h22)} & {{(VLEN/2){1'b1}}, {(VLEN/2){1'b0}}}
                                  | (rep(8'h11) & {{(VLEN/2){1'b0}}, {(VLEN/2){1'b1}}}));
      chk("split_uop", uop_cnt, 5);

      // write then stall for three cycles
      set_lane(0, 5'd5, 16'hFFFF, rep(8'h5A), 1'b1);
      rt_if.rt_valid = 4'b0001;
      cyc();
      chk("pre_stall_data5", wdat[5], rep(8'h5A));
      vrf_stall = 1'b1;
      set_lane(0, 5'd9, 16'hFFFF, rep(8'hFF), 1'b1);
      #1;
      chk("stall_ready", rt_if.rt_ready, 4'h0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("stall_hold_data5", wdat[5], rep(8'h5A));
         chk("stall_no_wenb9", wenb[9], '0);
         chk("stall_uop", uop_cnt, 6);
         chk("stall_insn", insn_cnt, 2);
      end
      vrf_stall      = 1'b0;
      rt_if.rt_valid = 4'b0000;
      cyc();
      chk("unstall_wenb5", wenb[5], '0);
      chk("unstall_uop", uop_cnt, 6);

      // all four lanes same register, last on lanes 1 and 3
      set_lane(0, 5'd1, 16'hFFFF, rep(8'h01), 1'b0);
      set_lane(1, 5'd1, 16'hFFFF, rep(8'h02), 1'b1);
      set_lane(2, 5'd1, 16'hFFFF, rep(8'h03), 1'b0);
      set_lane(3, 5'd1, 16'hFFFF, rep(8'h04), 1'b1);
      rt_if.rt_valid = 4'b1111;
      cyc();
      chk("all4_data1", wdat[1], rep(8'h04));
      chk("all4_uop", uop_cnt, 10);
      chk("all4_insn", insn_cnt, 4);

      // zero benb still counts; single byte enable
      set_lane(0, 5'd6, 16'h0000, rep(8'hFF), 1'b0);
      set_lane(1, 5'd8, 16'h0001, rep(8'hAB), 1'b0);
      rt_if.rt_valid = 4'b0011;
      cyc();
      chk("zb_wenb6", wenb[6], '0);
      chk("zb_data6", wdat[6], '0);
      chk("byte_wenb8", wenb[8], 128'hFF);
      chk("byte_data8", wdat[8], 128'hAB);
      chk("zb_uop", uop_cnt, 12);

      // counter wrap: 12 -> 14 -> 18 mod 16 = 2
      set_lane(0, 5'd10, 16'hFFFF, rep(8'h10), 1'b0);
      set_lane(1, 5'd11, 16'hFFFF, rep(8'h11), 1'b1);
      rt_if.rt_valid = 4'b0011;
      cyc();
      chk("pre_wrap_uop", uop_cnt, 14);
      chk("pre_wrap_insn", insn_cnt, 5);
      set_lane(0, 5'd12, 16'hFFFF, rep(8'h12), 1'b0);
      set_lane(1, 5'd13, 16'hFFFF, rep(8'h13), 1'b1);
      set_lane(2, 5'd14, 16'hFFFF, rep(8'h14), 1'b0);
      set_lane(3, 5'd15, 16'hFFFF, rep(8'h15), 1'b1);
      rt_if.rt_valid = 4'b1111;
      cyc();
      chk("wrap_uop", uop_cnt, 2);
      chk("wrap_insn", insn_cnt, 7);
      chk("wrap_data15", wdat[15], rep(8'h15));

      // non-contiguous lanes 0 and 2
      set_lane(0, 5'd4, 16'hFFFF, rep(8'h11), 1'b0);
      set_lane(2, 5'd4, 16'h000F, rep(8'h33), 1'b0);
      rt_if.rt_valid = 4'b0101;
      cyc();
      chk("gap_data4", wdat[4], {rep(8'h11)} & {{(VLEN-32){1'b1}}, 32'h0} | 128'h33333333);
      chk("gap_uop", uop_cnt, 4);
      chk("gap_err", order_err, exp_err);
      rt_if.rt_valid = 4'b0000;
      cyc();
      chk("gap_err_sticky", order_err, exp_err);
      chk("idle_wenb4", wenb[4], '0);

      // reset while a write is held by stall
      set_lane(0, 5'd4, 16'hFFFF, rep(8'h44), 1'b0);
      rt_if.rt_valid = 4'b0001;
      cyc();
      chk("held_data4", wdat[4], rep(8'h44));
      vrf_stall = 1'b1;
      rst_n     = 1'b0;
      cyc();
      chk("rst_stall_wenb4", wenb[4], '0);
      chk("rst_stall_data4", wdat[4], '0);
      chk("rst_stall_uop", uop_cnt, 0);
      chk("rst_stall_err", order_err, 0);
      rst_n          = 1'b1;
      vrf_stall      = 1'b0;
      rt_if.rt_valid = 4'b0000;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
